// File: rtl/sram_port0_arbiter_if.sv
// sram_port0_arbiter_if
//   Bundles everything port 0 of the cache data SRAM touches:
//   - the two requesters: A (refill/writeback) and B (core load/store),
//     each with a request channel and a read-response channel;
//   - the registered SRAM command outputs and the SRAM read data.
//   Modports:
//     slave  - the arbiter side (drives x_ready, x_rsp_*, sram_* commands)
//     master - the requester/SRAM side (drives requests, rsp_ready, sram_dout0)
interface sram_port0_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
);
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    logic                  a_valid,     b_valid;
    logic                  a_ready,     b_ready;
    logic                  a_we,        b_we;
    logic [NUM_WMASKS-1:0] a_wmask,     b_wmask;
    logic [ADDR_WIDTH-1:0] a_addr,      b_addr;
    logic [DATA_WIDTH-1:0] a_wdata,     b_wdata;
    logic                  a_rsp_valid, b_rsp_valid;
    logic                  a_rsp_ready, b_rsp_ready;
    logic [DATA_WIDTH-1:0] a_rdata,     b_rdata;

    logic                  sram_csb0;
    logic                  sram_web0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0;

    modport slave (
        input  a_valid, a_we, a_wmask, a_addr, a_wdata, a_rsp_ready,
        input  b_valid, b_we, b_wmask, b_addr, b_wdata, b_rsp_ready,
        output a_ready, a_rsp_valid, a_rdata,
        output b_ready, b_rsp_valid, b_rdata,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_dout0
    );

    modport master (
        output a_valid, a_we, a_wmask, a_addr, a_wdata, a_rsp_ready,
        output b_valid, b_we, b_wmask, b_addr, b_wdata, b_rsp_ready,
        input  a_ready, a_rsp_valid, a_rdata,
        input  b_ready, b_rsp_valid, b_rdata,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_dout0
    );
endinterface

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter
//   Owns the RW port (port 0) of the byte-masked cache data SRAM.
//   After reset it zero-fills the whole array (INIT), then arbitrates
//   between requester A (priority) and requester B (RUN). Every SRAM
//   command is registered; read data comes back two edges after the
//   accept edge into a per-requester response register.
// Ports
//   clk        clock, also the SRAM clk0
//   rst        asynchronous active-high reset
//   bus        sram_port0_arbiter_if.slave: A/B request + response
//              channels, SRAM command outputs, SRAM read data
//   init_done  high once the zero-fill has finished (state RUN)
module sram_port0_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_STALL  = 4,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_port0_arbiter_if.slave  bus,
    output logic                 init_done
);
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [3:0]            STALL_LIM = 4'(MAX_STALL);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [3:0]            starve_cnt;
    logic                  busy_a, busy_b;
    // Read tracking: vld_pipe[0] = read issued at the last edge,
    // vld_pipe[1] = its data is on sram_dout0 now. own_pipe: 1 = B.
    logic [1:0]            vld_pipe, own_pipe;

    logic                  run;
    logic                  a_hs, b_hs, a_free, b_free, a_cand, b_cand;
    logic                  gnt_a, gnt_b, rd_issue;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        run    = (state == ST_RUN);
        a_hs   = bus.a_rsp_valid && bus.a_rsp_ready;
        b_hs   = bus.b_rsp_valid && bus.b_rsp_ready;
        // A response being consumed this cycle frees the requester now, so
        // its next read can be accepted on the same edge.
        a_free = !busy_a || a_hs;
        b_free = !busy_b || b_hs;
        a_cand = run && bus.a_valid && a_free;
        b_cand = run && bus.b_valid && b_free;
        gnt_b  = b_cand && (!a_cand || (starve_cnt == STALL_LIM));
        gnt_a  = a_cand && !gnt_b;
        bus.a_ready = run && a_free && !(a_cand && gnt_b);
        bus.b_ready = run && b_free && !(b_cand && gnt_a);

        sel_we    = gnt_b ? bus.b_we    : bus.a_we;
        sel_wmask = gnt_b ? bus.b_wmask : bus.a_wmask;
        sel_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
        rd_issue  = (gnt_a || gnt_b) && !sel_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= INIT_EN ? ST_INIT : ST_RUN;
            init_done       <= !INIT_EN;
            cnt             <= '0;
            starve_cnt      <= '0;
            busy_a          <= 1'b0;
            busy_b          <= 1'b0;
            vld_pipe        <= '0;
            own_pipe        <= '0;
            bus.a_rsp_valid <= 1'b0;
            bus.b_rsp_valid <= 1'b0;
            bus.a_rdata     <= '0;
            bus.b_rdata     <= '0;
            bus.sram_csb0   <= 1'b1;
            bus.sram_web0   <= 1'b1;
            bus.sram_wmask0 <= '0;
            bus.sram_addr0  <= '0;
            bus.sram_din0   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_issue};
            own_pipe <= {own_pipe[0], gnt_b};

            // Response registers: clear on handshake, load when the owner's
            // data arrives. Both cannot coincide since a requester has at
            // most one read in flight.
            if (a_hs) bus.a_rsp_valid <= 1'b0;
            if (b_hs) bus.b_rsp_valid <= 1'b0;
            if (vld_pipe[1] && !own_pipe[1]) begin
                bus.a_rdata     <= bus.sram_dout0;
                bus.a_rsp_valid <= 1'b1;
            end
            if (vld_pipe[1] && own_pipe[1]) begin
                bus.b_rdata     <= bus.sram_dout0;
                bus.b_rsp_valid <= 1'b1;
            end

            if (state == ST_INIT) begin
                bus.sram_csb0   <= 1'b0;
                bus.sram_web0   <= 1'b0;
                bus.sram_wmask0 <= '1;
                bus.sram_addr0  <= cnt;
                bus.sram_din0   <= '0;
                cnt             <= cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
            end else begin
                if (gnt_a || gnt_b) begin
                    bus.sram_csb0   <= 1'b0;
                    bus.sram_web0   <= !sel_we;
                    bus.sram_wmask0 <= sel_we ? sel_wmask : '0;
                    bus.sram_addr0  <= sel_addr;
                    bus.sram_din0   <= sel_wdata;
                end else begin
                    // Idle: addr/din keep their last values to avoid toggling.
                    bus.sram_csb0   <= 1'b1;
                    bus.sram_web0   <= 1'b1;
                    bus.sram_wmask0 <= '0;
                end

                // A new read wins over a same-edge handshake clear.
                if (gnt_a && !bus.a_we) busy_a <= 1'b1;
                else if (a_hs)          busy_a <= 1'b0;
                if (gnt_b && !bus.b_we) busy_b <= 1'b1;
                else if (b_hs)          busy_b <= 1'b0;

                if (gnt_b)
                    starve_cnt <= '0;
                else if (b_cand && gnt_a && starve_cnt != STALL_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule
